color_pick_ctrl: RTL and testbench

//  Upstream game controller for the final-project board. Debounces three raw

---
 rtl/color_pick_ctrl_if.sv | 22 ++
 rtl/color_pick_ctrl.sv | 178 +++++++++++++++++
 tb/tb_color_pick_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_pick_ctrl_if.sv
// Raw button inputs and registered game-status outputs of the colour-pick controller.
interface color_pick_ctrl_if;
    logic       p1_btn;
    logic       p2_btn;
    logic       lock_btn;
    logic [1:0] c_value1;
    logic [1:0] c_value2;
    logic [2:0] round;
    logic [2:0] match_cnt;
    logic       match;
    logic       game_done;

    modport master (
        output p1_btn, p2_btn, lock_btn,
        input  c_value1, c_value2, round, match_cnt, match, game_done
    );

    modport slave (
        input  p1_btn, p2_btn, lock_btn,
        output c_value1, c_value2, round, match_cnt, match, game_done
    );
endinterface

// File: rtl/color_pick_ctrl.sv
// Two-player colour-pick game controller: three debounced buttons feed a
// round FSM that drives the LED colour values and the round/match display.
module color_pick_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_ROUND   = 5
) (
    input  logic             clk,
    input  logic             rst,
    color_pick_ctrl_if.slave io_bus
);
    localparam int         DCW        = $clog2(DEB_CYCLES + 1);
    localparam int         HCW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [2:0] LAST_ROUND = 3'(MAX_ROUND - 1);
    localparam logic [2:0] MATCH_SAT  = (MAX_ROUND > 7) ? 3'd7 : 3'(MAX_ROUND);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1_SEL,
        S_P2_SEL,
        S_RESULT,
        S_DONE
    } state_t;

    // Bit order for all button vectors: {lock, p2, p1}
    logic [2:0] w_raw;
    logic [2:0] w_press;

    assign w_raw = {io_bus.lock_btn, io_bus.p2_btn, io_bus.p1_btn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic           r_sync1;
            logic           r_sync2;
            logic           r_level;
            logic           r_level_d;
            logic           r_press;
            logic [DCW-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_press   <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    r_press   <= r_level & ~r_level_d;
                    // Level flips on the DEB_CYCLES-th consecutive disagreeing sample
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DCW'(DEB_CYCLES - 1)) begin
                        r_level <= ~r_level;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + DCW'(1);
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    logic w_p1_press;
    logic w_p2_press;
    logic w_lock_press;

    assign w_p1_press   = w_press[0];
    assign w_p2_press   = w_press[1];
    assign w_lock_press = w_press[2];

    state_t         r_state;
    logic [1:0]     r_col1;
    logic [1:0]     r_col2;
    logic [1:0]     r_c_value1;
    logic [1:0]     r_c_value2;
    logic [2:0]     r_round;
    logic [2:0]     r_match_cnt;
    logic           r_match;
    logic           r_game_done;
    logic [HCW-1:0] r_hold;
    logic [1:0]     w_col1_step;
    logic [1:0]     w_col2_step;

    // Colour cycles R,G,B and never returns to off once chosen
    assign w_col1_step = (r_col1 == 2'd3) ? 2'd1 : r_col1 + 2'd1;
    assign w_col2_step = (r_col2 == 2'd3) ? 2'd1 : r_col2 + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_col1      <= '0;
            r_col2      <= '0;
            r_c_value1  <= '0;
            r_c_value2  <= '0;
            r_round     <= '0;
            r_match_cnt <= '0;
            r_match     <= 1'b0;
            r_game_done <= 1'b0;
            r_hold      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lock_press) begin
                        r_state     <= S_P1_SEL;
                        r_round     <= '0;
                        r_match_cnt <= '0;
                        r_col1      <= '0;
                        r_col2      <= '0;
                        r_c_value1  <= '0;
                    end
                end
                S_P1_SEL: begin
                    if (w_lock_press && r_col1 != 2'd0) begin
                        r_state    <= S_P2_SEL;
                        r_c_value1 <= '0;
                        r_c_value2 <= r_col2;
                    end else if (w_p1_press) begin
                        r_col1     <= w_col1_step;
                        r_c_value1 <= w_col1_step;
                    end
                end
                S_P2_SEL: begin
                    if (w_lock_press && r_col2 != 2'd0) begin
                        r_state    <= S_RESULT;
                        r_c_value2 <= '0;
                        r_hold     <= '0;
                        r_match    <= (r_col1 == r_col2);
                        if (r_col1 == r_col2 && r_match_cnt < MATCH_SAT) begin
                            r_match_cnt <= r_match_cnt + 3'd1;
                        end
                    end else if (w_p2_press) begin
                        r_col2     <= w_col2_step;
                        r_c_value2 <= w_col2_step;
                    end
                end
                S_RESULT: begin
                    if (r_hold == HCW'(HOLD_CYCLES - 1)) begin
                        r_match <= 1'b0;
                        if (r_round == LAST_ROUND) begin
                            r_state     <= S_DONE;
                            r_game_done <= 1'b1;
                        end else begin
                            r_state    <= S_P1_SEL;
                            r_round    <= r_round + 3'd1;
                            r_col1     <= '0;
                            r_col2     <= '0;
                            r_c_value1 <= '0;
                        end
                    end else begin
                        r_hold <= r_hold + HCW'(1);
                    end
                end
                S_DONE: begin
                    if (w_lock_press) begin
                        r_state     <= S_IDLE;
                        r_game_done <= 1'b0;
                        r_round     <= '0;
                        r_match_cnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.c_value1  = r_c_value1;
    assign io_bus.c_value2  = r_c_value2;
    assign io_bus.round     = r_round;
    assign io_bus.match_cnt = r_match_cnt;
    assign io_bus.match     = r_match;
    assign io_bus.game_done = r_game_done;
endmodule

// File: tb/tb_color_pick_ctrl.sv
// Self-checking bench for color_pick_ctrl: directed table, multi-cycle corner
// sequences and a randomized game checked against a rule-level model.
module tb_color_pick_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int MAXR = 5;
    localparam int SEG  = DEB + 3;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] P1   = 3'b001;
    localparam logic [2:0] P2   = 3'b010;
    localparam logic [2:0] LK   = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b0;

    color_pick_ctrl_if bus ();

    color_pick_ctrl #(
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD),
        .MAX_ROUND  (MAXR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [11:0] mk(input int c1, input int c2, input int rnd,
                                       input int mc, input int m, input int d);
        return {2'(c1), 2'(c2), 3'(rnd), 3'(mc), 1'(m), 1'(d)};
    endfunction

    function automatic logic [11:0] dut_out();
        return {bus.c_value1, bus.c_value2, bus.round, bus.match_cnt, bus.match, bus.game_done};
    endfunction

    function automatic string fmt(input logic [11:0] v);
        return $sformatf("c1=%0d c2=%0d round=%0d match_cnt=%0d match=%0b done=%0b",
                         v[11:10], v[9:8], v[7:5], v[4:2], v[1], v[0]);
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: %s", name, fmt(got));
        end else begin
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("ok   %s: %0d", name, got);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic set_btn(input logic [2:0] mask);
        bus.p1_btn   = mask[0];
        bus.p2_btn   = mask[1];
        bus.lock_btn = mask[2];
    endtask

    // One clean press: held SEG cycles, released SEG cycles; starts and ends at a negedge
    task automatic press(input logic [2:0] mask);
        set_btn(mask);
        repeat (SEG) @(negedge clk);
        set_btn(NONE);
        repeat (SEG) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_btn(NONE);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Rule-level game model
    localparam int G_IDLE = 0, G_SEL1 = 1, G_SEL2 = 2, G_RES = 3, G_DONE = 4;
    int m_phase, m_col1, m_col2, m_round, m_mc;

    function automatic int next_colour(input int c);
        return (c % 3) + 1;
    endfunction

    task automatic model_press(input logic [2:0] mask);
        case (m_phase)
            G_IDLE: if (mask[2]) begin
                m_phase = G_SEL1; m_round = 0; m_mc = 0; m_col1 = 0; m_col2 = 0;
            end
            G_SEL1: begin
                if (mask[2] && m_col1 != 0) m_phase = G_SEL2;
                else if (mask[0]) m_col1 = next_colour(m_col1);
            end
            G_SEL2: begin
                if (mask[2] && m_col2 != 0) begin
                    m_phase = G_RES;
                    if (m_col1 == m_col2 && m_mc < MAXR) m_mc++;
                end else if (mask[1]) m_col2 = next_colour(m_col2);
            end
            G_DONE: if (mask[2]) m_phase = G_IDLE;
            default: ;
        endcase
    endtask

    task automatic model_result_elapsed();
        if (m_phase == G_RES) begin
            if (m_round == MAXR - 1) m_phase = G_DONE;
            else begin
                m_round++; m_col1 = 0; m_col2 = 0; m_phase = G_SEL1;
            end
        end
    endtask

    function automatic logic [11:0] model_exp();
        int idle;
        idle = (m_phase == G_IDLE);
        return mk((m_phase == G_SEL1) ? m_col1 : 0,
                  (m_phase == G_SEL2) ? m_col2 : 0,
                  idle ? 0 : m_round,
                  idle ? 0 : m_mc,
                  (m_phase == G_RES && m_col1 == m_col2) ? 1 : 0,
                  (m_phase == G_DONE) ? 1 : 0);
    endfunction

    typedef struct packed {
        logic [2:0]  mask;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [11:0] acc;
        int          lat;
        logic [2:0]  m;

        set_btn(NONE);

        // Reset held with buttons bouncing: outputs must stay 0
        acc = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            acc |= dut_out();
            set_btn(3'($urandom_range(0, 7)));
        end
        @(negedge clk);
        acc |= dut_out();
        check("reset_hold_outputs_zero", acc, mk(0, 0, 0, 0, 0, 0));

        // Release reset with lock held -> single lock press, P1_SEL
        set_btn(LK);
        rst = 1'b1;
        repeat (SEG) @(negedge clk);
        set_btn(NONE);
        repeat (SEG) @(negedge clk);
        check("after_release_lock_held", dut_out(), mk(0, 0, 0, 0, 0, 0));

        // 3-cycle glitch must not register
        set_btn(P1);
        repeat (3) @(negedge clk);
        set_btn(NONE);
        repeat (SEG + 3) @(negedge clk);
        check("glitch_ignored", dut_out(), mk(0, 0, 0, 0, 0, 0));

        // 10-cycle hold: exact latency, single step, no auto-repeat
        lat = -1;
        set_btn(P1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (lat < 0 && bus.c_value1 != 2'd0) lat = i - 1;
        end
        set_btn(NONE);
        check_int("p1_press_to_output_latency", lat, DEB + 3);
        repeat (SEG + 3) @(negedge clk);
        check("long_hold_single_step", dut_out(), mk(1, 0, 0, 0, 0, 0));
        press(LK);
        check("lock_to_p2_sel", dut_out(), mk(0, 0, 0, 0, 0, 0));

        // Directed game table from a fresh reset
        tbl.push_back({LK, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back({P2, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back({P1, mk(1, 0, 0, 0, 0, 0)});
        tbl.push_back({P1, mk(2, 0, 0, 0, 0, 0)});
        tbl.push_back({P1, mk(3, 0, 0, 0, 0, 0)});
        tbl.push_back({P1, mk(1, 0, 0, 0, 0, 0)});
        tbl.push_back({P1, mk(2, 0, 0, 0, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back({P2, mk(0, 1, 0, 0, 0, 0)});
        tbl.push_back({P2, mk(0, 2, 0, 0, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 0, 1, 1, 0)});
        tbl.push_back({NONE, mk(0, 0, 1, 1, 0, 0)});
        tbl.push_back({P1, mk(1, 0, 1, 1, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 1, 1, 0, 0)});
        tbl.push_back({P2, mk(0, 1, 1, 1, 0, 0)});
        tbl.push_back({P2, mk(0, 2, 1, 1, 0, 0)});
        tbl.push_back({P2, mk(0, 3, 1, 1, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 1, 1, 0, 0)});
        tbl.push_back({NONE, mk(0, 0, 2, 1, 0, 0)});
        tbl.push_back({P1, mk(1, 0, 2, 1, 0, 0)});
        tbl.push_back({P1, mk(2, 0, 2, 1, 0, 0)});
        tbl.push_back({P1, mk(3, 0, 2, 1, 0, 0)});
        tbl.push_back({P1 | LK, mk(0, 0, 2, 1, 0, 0)});
        tbl.push_back({P2 | LK, mk(0, 1, 2, 1, 0, 0)});
        tbl.push_back({P2, mk(0, 2, 2, 1, 0, 0)});
        tbl.push_back({P2, mk(0, 3, 2, 1, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 2, 2, 1, 0)});
        tbl.push_back({NONE, mk(0, 0, 3, 2, 0, 0)});
        tbl.push_back({P1, mk(1, 0, 3, 2, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 3, 2, 0, 0)});
        tbl.push_back({P2, mk(0, 1, 3, 2, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 3, 3, 1, 0)});
        tbl.push_back({NONE, mk(0, 0, 4, 3, 0, 0)});
        tbl.push_back({P1, mk(1, 0, 4, 3, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 4, 3, 0, 0)});
        tbl.push_back({P2, mk(0, 1, 4, 3, 0, 0)});
        tbl.push_back({P2, mk(0, 2, 4, 3, 0, 0)});
        tbl.push_back({LK, mk(0, 0, 4, 3, 0, 0)});
        tbl.push_back({NONE, mk(0, 0, 4, 3, 0, 1)});
        tbl.push_back({P1, mk(0, 0, 4, 3, 0, 1)});
        tbl.push_back({LK, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back({P1, mk(0, 0, 0, 0, 0, 0)});

        do_reset();
        foreach (tbl[i]) begin
            press(tbl[i].mask);
            check($sformatf("table[%0d] mask=%03b", i, tbl[i].mask), dut_out(), tbl[i].exp);
        end

        // Asynchronous reset in the middle of RESULT
        press(LK); press(P1); press(LK); press(P2); press(LK);
        check("result_before_async_reset", dut_out(), mk(0, 0, 0, 1, 1, 0));
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_before_edge", dut_out(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        press(P1);
        check("idle_after_async_reset", dut_out(), mk(0, 0, 0, 0, 0, 0));

        // Randomized play against the rule-level model
        do_reset();
        m_phase = G_IDLE; m_col1 = 0; m_col2 = 0; m_round = 0; m_mc = 0;
        for (int t = 0; t < 60; t++) begin
            m = 3'($urandom_range(1, 7));
            press(m);
            model_press(m);
            check($sformatf("rand[%0d] mask=%03b", t, m), dut_out(), model_exp());
            if (m_phase == G_RES) begin
                press(NONE);
                model_result_elapsed();
                check($sformatf("rand[%0d] after_result", t), dut_out(), model_exp());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
